// File: rtl/forward_unit_pkg.sv
// Shared types for the commit-to-execute operand forwarding path.
// Holds the default widths and the forward_t bundle that execute consumes.
package forward_unit_pkg;
  localparam int ALU_NUM_DEF = 2;
  localparam int FU_NUM_DEF  = 4;
  localparam int PREG_W_DEF  = 6;
  localparam int FWD_DEPTH   = 2;

  typedef logic [31:0]            word_t;
  typedef logic [PREG_W_DEF-1:0]  preg_addr_t;

  typedef struct packed {
    logic  valid1;
    word_t data1;
    logic  valid2;
    word_t data2;
  } forward_t;

  typedef struct packed {
    logic       valid;
    preg_addr_t preg;
    word_t      data;
  } fwd_entry_t;
endpackage

// File: rtl/forward_unit_lookup.sv
// Priority match of one source address against an ordered candidate list.
// Candidate 0 is the newest result; the lowest matching index wins.
module forward_unit_lookup
  import forward_unit_pkg::*;
#(
  parameter int N      = 6,
  parameter int PREG_W = PREG_W_DEF
) (
  input  logic [PREG_W-1:0]         addr,
  input  logic [N-1:0]              cand_valid,
  input  logic [N-1:0][PREG_W-1:0]  cand_preg,
  input  word_t [N-1:0]             cand_data,
  output logic                      hit,
  output word_t                     value
);
  // Scan oldest to newest so the newest match overwrites earlier ones.
  always_comb begin
    hit   = 1'b0;
    value = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (cand_valid[j] && (cand_preg[j] == addr) && (addr != '0)) begin
        hit   = 1'b1;
        value = cand_data[j];
      end
    end
  end
endmodule

// File: rtl/forward_unit.sv
// Keeps a DEPTH-cycle window of retired results and forwards them to the
// execute operand muxes until the register file can supply them.
module forward_unit
  import forward_unit_pkg::*;
#(
  parameter int ALU_NUM = ALU_NUM_DEF,
  parameter int FU_NUM  = FU_NUM_DEF,
  parameter int PREG_W  = PREG_W_DEF,
  parameter int DEPTH   = FWD_DEPTH
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             flush,
  input  logic [ALU_NUM-1:0][PREG_W-1:0]   src1,
  input  logic [ALU_NUM-1:0][PREG_W-1:0]   src2,
  input  logic [ALU_NUM-1:0][PREG_W-1:0]   dst,
  input  word_t [ALU_NUM-1:0]              data,
  output forward_t [FU_NUM-1:0]            forwards,
  output logic [31:0]                      hit_cnt
);
  localparam int N_CAND = ALU_NUM * (DEPTH + 1);
  localparam int CNT_W  = $clog2(2 * ALU_NUM + 1);

  logic [DEPTH-1:0][ALU_NUM-1:0]              hv;
  logic [DEPTH-1:0][ALU_NUM-1:0][PREG_W-1:0]  hp;
  word_t [DEPTH-1:0][ALU_NUM-1:0]             hd;

  logic [N_CAND-1:0]              cv;
  logic [N_CAND-1:0][PREG_W-1:0]  cp;
  word_t [N_CAND-1:0]             cd;

  logic [ALU_NUM-1:0]   h1, h2;
  word_t [ALU_NUM-1:0]  v1, v2;
  logic [CNT_W-1:0]     hits;
  logic [32:0]          cnt_sum;

  // Generation 0 is the newest history; flush clears only the valid bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hv <= '0;
      hp <= '0;
      hd <= '0;
    end else begin
      for (int g = DEPTH - 1; g > 0; g--) begin
        hv[g] <= hv[g-1];
        hp[g] <= hp[g-1];
        hd[g] <= hd[g-1];
      end
      for (int s = 0; s < ALU_NUM; s++) begin
        hv[0][s] <= (dst[s] != '0);
      end
      hp[0] <= dst;
      hd[0] <= data;
      if (flush) hv <= '0;
    end
  end

  // Candidate order: live commit, then gen 0..DEPTH-1; higher slot first within each.
  always_comb begin
    cv = '0;
    cp = '0;
    cd = '0;
    for (int s = 0; s < ALU_NUM; s++) begin
      cv[ALU_NUM-1-s] = (dst[s] != '0);
      cp[ALU_NUM-1-s] = dst[s];
      cd[ALU_NUM-1-s] = data[s];
      for (int g = 0; g < DEPTH; g++) begin
        cv[(g+1)*ALU_NUM + ALU_NUM-1-s] = hv[g][s];
        cp[(g+1)*ALU_NUM + ALU_NUM-1-s] = hp[g][s];
        cd[(g+1)*ALU_NUM + ALU_NUM-1-s] = hd[g][s];
      end
    end
  end

  for (genvar i = 0; i < ALU_NUM; i++) begin : g_alu
    forward_unit_lookup #(.N(N_CAND), .PREG_W(PREG_W)) u_lk1 (
      .addr(src1[i]), .cand_valid(cv), .cand_preg(cp), .cand_data(cd),
      .hit(h1[i]), .value(v1[i])
    );
    forward_unit_lookup #(.N(N_CAND), .PREG_W(PREG_W)) u_lk2 (
      .addr(src2[i]), .cand_valid(cv), .cand_preg(cp), .cand_data(cd),
      .hit(h2[i]), .value(v2[i])
    );
  end

  always_comb begin
    forwards = '0;
    hits     = '0;
    for (int i = 0; i < ALU_NUM; i++) begin
      forwards[i].valid1 = h1[i];
      forwards[i].data1  = v1[i];
      forwards[i].valid2 = h2[i];
      forwards[i].data2  = v2[i];
      hits = hits + CNT_W'(h1[i]) + CNT_W'(h2[i]);
    end
  end

  assign cnt_sum = {1'b0, hit_cnt} + 33'(hits);

  // Saturating; survives flush so it reflects total forwarding activity.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hit_cnt <= '0;
    else         hit_cnt <= cnt_sum[32] ? '1 : cnt_sum[31:0];
  end
endmodule

// File: tb/tb_forward_unit.sv
// Bench for forward_unit: directed scenarios plus random traffic checked
// against a commit-log reference model.
module tb_forward_unit;
  import forward_unit_pkg::*;

  localparam int ALU_NUM = 2;
  localparam int FU_NUM  = 4;
  localparam int PREG_W  = 6;
  localparam int DEPTH   = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush = 1'b0;
  logic [ALU_NUM-1:0][PREG_W-1:0] src1, src2, dst;
  word_t [ALU_NUM-1:0]            data;
  forward_t [FU_NUM-1:0]          forwards;
  logic [31:0]                    hit_cnt;

  forward_unit #(.ALU_NUM(ALU_NUM), .FU_NUM(FU_NUM), .PREG_W(PREG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .src1(src1), .src2(src2), .dst(dst), .data(data),
    .forwards(forwards), .hit_cnt(hit_cnt)
  );

  // clock/reset
  always #5 clk = ~clk;

  // reference model: log of every captured commit, in commit order
  typedef struct {
    int          cyc;
    int          preg;
    logic [31:0] data;
  } commit_rec_t;

  commit_rec_t log_q[$];
  logic [65:0] exp_q[$];
  int          now = 0;
  int          kill_mark = -1;
  logic [31:0] exp_hit = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, now);
    end
  endtask

  // Newest live commit first, then captured commits still inside the window.
  function automatic logic [32:0] ref_lookup(input int addr);
    if (addr == 0) return '0;
    for (int s = ALU_NUM - 1; s >= 0; s--)
      if (int'(dst[s]) == addr) return {1'b1, data[s]};
    for (int k = log_q.size() - 1; k >= 0; k--) begin
      if (log_q[k].cyc < now - DEPTH) break;
      if (log_q[k].cyc > kill_mark && log_q[k].preg == addr) return {1'b1, log_q[k].data};
    end
    return '0;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    flush = 1'b0;
    src1 = '0;
    src2 = '0;
    dst  = '0;
    data = '0;
  endtask

  // Checks the current cycle at the negedge, advances the model, then steps past the posedge.
  task automatic step(input string tag);
    int          hits;
    logic [32:0] r1, r2, tot;
    hits = 0;
    @(negedge clk);
    for (int i = 0; i < ALU_NUM; i++) begin
      r1 = ref_lookup(int'(src1[i]));
      r2 = ref_lookup(int'(src2[i]));
      exp_q.push_back({r1, r2});
      hits += int'(r1[32]) + int'(r2[32]);
    end
    for (int i = 0; i < ALU_NUM; i++)
      check({tag, "_fwd"}, forwards[i], exp_q.pop_front());
    for (int i = ALU_NUM; i < FU_NUM; i++)
      check({tag, "_unused_fu"}, forwards[i], 66'd0);
    check({tag, "_hit_cnt"}, {34'd0, hit_cnt}, {34'd0, exp_hit});
    tot = {1'b0, exp_hit} + 33'(hits);
    exp_hit = tot[32] ? 32'hFFFF_FFFF : tot[31:0];
    if (flush) kill_mark = now;
    else
      for (int s = 0; s < ALU_NUM; s++)
        if (dst[s] != '0) log_q.push_back('{cyc: now, preg: int'(dst[s]), data: data[s]});
    @(posedge clk);
    #1;
    now++;
  endtask

  initial begin
    idle_inputs();
    #12;
    check("reset_hit_cnt", {34'd0, hit_cnt}, 66'd0);
    check("reset_fwd0", forwards[0], 66'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // reset then idle
    src1[0] = 6'd5;
    step("idle");

    // same-cycle bypass
    idle_inputs();
    dst[0] = 6'd5; data[0] = 32'hDEAD_BEEF; src1[1] = 6'd5;
    step("bypass");
    idle_inputs();
    step("bypass_after");
    check("bypass_cnt", {34'd0, hit_cnt}, 66'd1);

    // window expiry: hits for t..t+2, miss at t+3
    idle_inputs();
    dst[1] = 6'd7; data[1] = 32'h11; src2[0] = 6'd7;
    step("expiry_t0");
    dst = '0; data = '0;
    for (int k = 1; k <= DEPTH + 1; k++) step("expiry");

    // priority across cycles
    idle_inputs();
    dst[0] = 6'd9; data[0] = 32'hAA;
    step("prio_a");
    dst[0] = 6'd9; data[0] = 32'hBB; src1[0] = 6'd9;
    step("prio_b");
    // priority within one cycle
    idle_inputs();
    dst[0] = 6'd9; dst[1] = 6'd9; data[0] = 32'd1; data[1] = 32'd2; src2[1] = 6'd9;
    step("prio_slot");
    dst = '0; data = '0;
    step("prio_slot_hist");

    // zero register
    idle_inputs();
    data[0] = 32'h55;
    step("zero_reg");

    // flush drops history after the edge
    idle_inputs();
    dst[0] = 6'd3; data[0] = 32'h42;
    step("flush_commit");
    idle_inputs();
    flush = 1'b1; src1[0] = 6'd3;
    step("flush_cycle");
    flush = 1'b0;
    step("flush_after");

    // asynchronous reset mid-window
    idle_inputs();
    dst[0] = 6'd4; data[0] = 32'h4444;
    step("arst_commit");
    idle_inputs();
    src1[0] = 6'd4;
    #2;
    check("arst_pre", forwards[0], {ref_lookup(4), 33'd0});
    resetn = 1'b0;
    #1;
    kill_mark = now;
    exp_hit = '0;
    check("arst_fwd", forwards[0], 66'd0);
    check("arst_hit_cnt", {34'd0, hit_cnt}, 66'd0);
    resetn = 1'b1;
    step("arst_after");

    // random traffic over a small register space so matches are frequent
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < ALU_NUM; i++) begin
        dst[i]  = PREG_W'($urandom_range(0, 7));
        data[i] = $urandom;
        src1[i] = PREG_W'($urandom_range(0, 7));
        src2[i] = PREG_W'($urandom_range(0, 7));
      end
      step("rand");
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
